// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the pixel pipeline (slave).
// With VGA_TIMING_LINE_IRQ_EN defined the bundle also carries line_irq.
interface vga_timing_if #(
    parameter int unsigned CW = 10
);
    logic          ce;
    logic          vga_HS;
    logic          vga_VS;
    logic          de;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_TIMING_LINE_IRQ_EN
    logic          line_irq;

    modport master (
        input  ce,
        output vga_HS, vga_VS, de, pixel_x, pixel_y, line_start, frame_start, line_irq
    );
    modport slave (
        output ce,
        input  vga_HS, vga_VS, de, pixel_x, pixel_y, line_start, frame_start, line_irq
    );
`else
    modport master (
        input  ce,
        output vga_HS, vga_VS, de, pixel_x, pixel_y, line_start, frame_start
    );
    modport slave (
        output ce,
        input  vga_HS, vga_VS, de, pixel_x, pixel_y, line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: owns the x/y counters, registers sync/de/strobes.
// Optional feature: define VGA_TIMING_LINE_IRQ_EN to add IRQ_LINE and the line_irq pulse.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
`ifdef VGA_TIMING_LINE_IRQ_EN
    ,
    parameter int unsigned IRQ_LINE = 480
`endif
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic [CW-1:0] w_nx;
    logic [CW-1:0] w_ny;
    logic          w_hwrap;
    logic          w_vwrap;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_de;

    // Next position and its decode; registering the decode keeps syncs aligned with the coordinates.
    always_comb begin
        w_hwrap = (r_x == H_LAST);
        w_vwrap = w_hwrap && (r_y == V_LAST);
        w_nx    = w_hwrap ? '0 : r_x + CW'(1);
        w_ny    = r_y;
        if (w_vwrap) begin
            w_ny = '0;
        end else if (w_hwrap) begin
            w_ny = r_y + CW'(1);
        end
        w_de    = (w_nx < H_ACT) && (w_ny < V_ACT);
        w_hs_on = (w_nx >= H_HS_BEG) && (w_nx < H_HS_END);
        w_vs_on = (w_ny >= V_VS_BEG) && (w_ny < V_VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_de          <= 1'b0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes last one clk even when ce stays low afterwards.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (vga.ce) begin
                r_x           <= w_nx;
                r_y           <= w_ny;
                r_de          <= w_de;
                r_hs          <= w_hs_on ? HS_POL : ~HS_POL;
                r_vs          <= w_vs_on ? VS_POL : ~VS_POL;
                r_line_start  <= w_hwrap;
                r_frame_start <= w_vwrap;
            end
        end
    end

    assign vga.pixel_x     = r_x;
    assign vga.pixel_y     = r_y;
    assign vga.de          = r_de;
    assign vga.vga_HS      = r_hs;
    assign vga.vga_VS      = r_vs;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

`ifdef VGA_TIMING_LINE_IRQ_EN
    // Lines beyond the frame can never be reached, so the pulse is tied off for them.
    localparam bit            IRQ_OK = (IRQ_LINE < V_TOTAL);
    localparam logic [CW-1:0] IRQ_Y  = IRQ_OK ? CW'(IRQ_LINE) : '0;

    logic r_line_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_irq <= 1'b0;
        end else begin
            r_line_irq <= IRQ_OK && vga.ce && w_hwrap && (w_ny == IRQ_Y);
        end
    end

    assign vga.line_irq = r_line_irq;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 14x7 raster with active-high syncs,
// compared every clk against a linear-pixel-index reference model.
module tb_vga_timing_gen;
    localparam int unsigned HA  = 8;
    localparam int unsigned HF  = 2;
    localparam int unsigned HSW = 3;
    localparam int unsigned HB  = 1;
    localparam int unsigned VA  = 4;
    localparam int unsigned VF  = 1;
    localparam int unsigned VSW = 1;
    localparam int unsigned VB  = 1;
    localparam int unsigned HT  = 14;
    localparam int unsigned VT  = 7;
    localparam int unsigned FT  = HT * VT;
    localparam int unsigned CW  = 4;
    localparam int unsigned IRQ = 4;

    logic clk;
    logic reset;

    int total;
    int bad;
    int p;
    int cyc;
    int last_ls;
    int last_fs;
    int per_ls;
    int per_fs;
    logic e_de, e_hs, e_vs, e_ls, e_fs, e_irq;

    vga_timing_if #(.CW(CW)) vga ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
`ifdef VGA_TIMING_LINE_IRQ_EN
        , .IRQ_LINE(IRQ)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vga)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clk: apply inputs, advance the reference model, compare every output.
    task automatic step(input logic c, input logic r);
        int x;
        int y;
        vga.ce = c;
        reset  = r;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            p = FT - 1;
            e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
            e_ls = 1'b0; e_fs = 1'b0; e_irq = 1'b0;
        end else if (c) begin
            p    = (p + 1) % FT;
            x    = p % HT;
            y    = p / HT;
            e_de = (x < HA) && (y < VA);
            e_hs = (x >= HA + HF) && (x < HA + HF + HSW);
            e_vs = (y >= VA + VF) && (y < VA + VF + VSW);
            e_ls = (x == 0);
            e_fs = (p == 0);
            e_irq = (p == IRQ * HT);
        end else begin
            e_ls = 1'b0; e_fs = 1'b0; e_irq = 1'b0;
        end
        chk("pixel_x",     32'(vga.pixel_x),     32'(p % HT));
        chk("pixel_y",     32'(vga.pixel_y),     32'(p / HT));
        chk("de",          32'(vga.de),          32'(e_de));
        chk("vga_HS",      32'(vga.vga_HS),      32'(e_hs));
        chk("vga_VS",      32'(vga.vga_VS),      32'(e_vs));
        chk("line_start",  32'(vga.line_start),  32'(e_ls));
        chk("frame_start", 32'(vga.frame_start), 32'(e_fs));
`ifdef VGA_TIMING_LINE_IRQ_EN
        chk("line_irq",    32'(vga.line_irq),    32'(e_irq));
`endif
        // Strobe periods, measured only in phases with a fixed ce pattern.
        if (vga.line_start === 1'b1) begin
            if (per_ls > 0 && last_ls >= 0) chk("line_period", 32'(cyc - last_ls), 32'(per_ls));
            last_ls = cyc;
        end
        if (vga.frame_start === 1'b1) begin
            if (per_fs > 0 && last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(per_fs));
            last_fs = cyc;
        end
    endtask

    task automatic set_period(input int pl, input int pf);
        per_ls  = pl;
        per_fs  = pf;
        last_ls = -1;
        last_fs = -1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        p     = FT - 1;
        set_period(0, 0);
        vga.ce = 1'b0;
        reset  = 1'b1;

        // Reset state, then continuous ce for two full frames.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        set_period(HT, FT);
        for (int i = 0; i < 2 * FT + 5; i++) step(1'b1, 1'b0);

        // ce 1-in-2: periods double, strobes still one clk.
        set_period(2 * HT, 2 * FT);
        for (int i = 0; i < 4 * FT + 6; i++) step(1'(i % 2 == 0), 1'b0);

        // Mid-frame reset, then first tick after release lands on (0,0).
        set_period(0, 0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("first_tick_fs", 32'(vga.frame_start), 32'd1);

        // Random ce duty with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
        end

        // Long ce-low stretch: levels hold, strobes stay low.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        for (int i = 0; i < FT; i++) step(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
